// File: rtl/ps2_poly_note_tracker_pkg.sv
// Shared constants, key map and prefix FSM states for the PS/2 note tracker.
// Optional sustain pedal is enabled by defining SUSTAIN_PEDAL_EN.
package ps2_poly_note_tracker_pkg;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_OCT_DN = 8'h4E;
  localparam logic [7:0] SC_OCT_UP = 8'h55;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam int KEY_W    = 5;
  localparam int NUM_KEYS = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } pfx_state_t;

  // Piano-style layout on the home/top rows, then the bottom row
  function automatic logic [KEY_W-1:0] key_index(input logic [7:0] code);
    case (code)
      8'h1C:   return 5'd1;
      8'h1D:   return 5'd2;
      8'h1B:   return 5'd3;
      8'h24:   return 5'd4;
      8'h23:   return 5'd5;
      8'h2B:   return 5'd6;
      8'h2C:   return 5'd7;
      8'h34:   return 5'd8;
      8'h35:   return 5'd9;
      8'h33:   return 5'd10;
      8'h3C:   return 5'd11;
      8'h3B:   return 5'd12;
      8'h42:   return 5'd13;
      8'h44:   return 5'd14;
      8'h4B:   return 5'd15;
      8'h4D:   return 5'd16;
      8'h4C:   return 5'd17;
      8'h52:   return 5'd18;
      8'h5B:   return 5'd19;
      8'h5D:   return 5'd20;
      8'h5A:   return 5'd21;
      8'h1A:   return 5'd22;
      8'h22:   return 5'd23;
      8'h21:   return 5'd24;
      8'h2A:   return 5'd25;
      default: return 5'd0;
    endcase
  endfunction

  // True when the highest reachable note fits in note_w bits
  function automatic bit note_w_ok(input int note_w, input int oct_max);
    return (NUM_KEYS + 12 * oct_max) < (1 << note_w);
  endfunction

endpackage

// File: rtl/ps2_poly_note_tracker_if.sv
// Byte stream from the PS/2 receiver into the note tracker.
// The receiver side drives, the tracker side samples.
interface ps2_poly_note_tracker_if;
  logic [7:0] scan_code;
  logic       scan_valid;

  modport master (output scan_code, output scan_valid);
  modport slave  (input scan_code, input scan_valid);
endinterface

// File: rtl/ps2_make_break_decoder.sv
// Prefix FSM: turns raw set-2 bytes into make/break strobes.
// Extended (E0) codes are swallowed here and never reach the voices.
module ps2_make_break_decoder
  import ps2_poly_note_tracker_pkg::*;
(
  input  logic                     CLOCK_50,
  input  logic                     reset,
  ps2_poly_note_tracker_if.slave   scan,
  output logic                     make_stb,
  output logic                     brk_stb,
  output logic [7:0]               key_code
);

  pfx_state_t state;

  // Track prefixes and emit one registered strobe per plain key byte
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= ST_IDLE;
      make_stb <= 1'b0;
      brk_stb  <= 1'b0;
      key_code <= 8'h00;
    end else begin
      make_stb <= 1'b0;
      brk_stb  <= 1'b0;
      if (scan.scan_valid) begin
        unique case (state)
          ST_IDLE: begin
            if (scan.scan_code == SC_BRK) begin
              state <= ST_BRK;
            end else if (scan.scan_code == SC_EXT) begin
              state <= ST_EXT;
            end else begin
              make_stb <= 1'b1;
              key_code <= scan.scan_code;
            end
          end
          ST_BRK: begin
            brk_stb  <= 1'b1;
            key_code <= scan.scan_code;
            state    <= ST_IDLE;
          end
          ST_EXT: begin
            if (scan.scan_code == SC_BRK) state <= ST_EXT_BRK;
            else                          state <= ST_IDLE;
          end
          ST_EXT_BRK: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_poly_note_tracker.sv
// Polyphonic note tracker: voice table, allocator, steal pointer, octave.
// Define SUSTAIN_PEDAL_EN to make the space bar act as a sustain pedal.
module ps2_poly_note_tracker
  import ps2_poly_note_tracker_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 7,
  parameter int OCTAVE_MAX = 3,
  parameter int OCTAVE_RST = 1
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  ps2_poly_note_tracker_if.slave       scan,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [1:0]                   octave,
  output logic                         note_on_pulse,
  output logic                         note_off_pulse,
  output logic [NOTE_W-1:0]            event_note
);

  localparam int PW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic             make_stb;
  logic             brk_stb;
  logic [7:0]       key_code;

  logic [KEY_W-1:0]  vkey  [NUM_VOICES];
  logic [NOTE_W-1:0] vnote [NUM_VOICES];
  logic [PW-1:0]     steal_ptr;
  logic [PW-1:0]     steal_nxt;

  logic [KEY_W-1:0]  kidx;
  logic [NOTE_W-1:0] new_note;
  logic              hit;
  logic              has_free;
  logic [PW-1:0]     hit_v;
  logic [PW-1:0]     free_v;
  logic [PW-1:0]     alloc_v;

`ifdef SUSTAIN_PEDAL_EN
  logic                  sustain;
  logic [NUM_VOICES-1:0] pending;
  logic                  has_pend;
  logic [PW-1:0]         pend_v;
`endif

  ps2_make_break_decoder u_dec (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .scan     (scan),
    .make_stb (make_stb),
    .brk_stb  (brk_stb),
    .key_code (key_code)
  );

  // Key lookup, current note and lowest-numbered match/free/pending voice
  always_comb begin
    kidx      = key_index(key_code);
    new_note  = NOTE_W'(kidx) + NOTE_W'(32'd12 * octave);
    hit       = 1'b0;
    hit_v     = '0;
    has_free  = 1'b0;
    free_v    = '0;
`ifdef SUSTAIN_PEDAL_EN
    has_pend  = 1'b0;
    pend_v    = '0;
`endif
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voice_active[v] && vkey[v] == kidx) begin
        hit   = 1'b1;
        hit_v = PW'(v);
      end
      if (!voice_active[v]) begin
        has_free = 1'b1;
        free_v   = PW'(v);
      end
`ifdef SUSTAIN_PEDAL_EN
      if (pending[v]) begin
        has_pend = 1'b1;
        pend_v   = PW'(v);
      end
`endif
    end
    if (steal_ptr == PW'(NUM_VOICES - 1)) steal_nxt = '0;
    else                                  steal_nxt = steal_ptr + 1'b1;
`ifdef SUSTAIN_PEDAL_EN
    alloc_v = has_free ? free_v : (has_pend ? pend_v : steal_ptr);
`else
    alloc_v = has_free ? free_v : steal_ptr;
`endif
  end

  // Flatten the note table onto the voice bus
  always_comb begin
    voice_note = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_note[v*NOTE_W +: NOTE_W] = vnote[v];
    end
  end

  // Voice table, octave and event pulses react to decoded strobes
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      voice_active   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey[v]  <= '0;
        vnote[v] <= '0;
      end
      steal_ptr      <= '0;
      octave         <= 2'(OCTAVE_RST);
      note_on_pulse  <= 1'b0;
      note_off_pulse <= 1'b0;
      event_note     <= '0;
`ifdef SUSTAIN_PEDAL_EN
      sustain        <= 1'b0;
      pending        <= '0;
`endif
    end else begin
      note_on_pulse  <= 1'b0;
      note_off_pulse <= 1'b0;
      if (make_stb) begin
        if (key_code == SC_OCT_DN) begin
          if (octave != 2'd0) octave <= octave - 2'd1;
        end else if (key_code == SC_OCT_UP) begin
          if (octave != 2'(OCTAVE_MAX)) octave <= octave + 2'd1;
`ifdef SUSTAIN_PEDAL_EN
        end else if (key_code == SC_SPACE) begin
          sustain <= 1'b1;
        end else if (kidx != '0 && hit && pending[hit_v]) begin
          pending[hit_v] <= 1'b0;
          note_on_pulse  <= 1'b1;
          event_note     <= vnote[hit_v];
`endif
        end else if (kidx != '0 && !hit) begin
          voice_active[alloc_v] <= 1'b1;
          vkey[alloc_v]         <= kidx;
          vnote[alloc_v]        <= new_note;
          note_on_pulse         <= 1'b1;
          event_note            <= new_note;
`ifdef SUSTAIN_PEDAL_EN
          if (!has_free && has_pend) pending[pend_v] <= 1'b0;
          else if (!has_free)        steal_ptr <= steal_nxt;
`else
          if (!has_free) steal_ptr <= steal_nxt;
`endif
        end
      end else if (brk_stb) begin
`ifdef SUSTAIN_PEDAL_EN
        if (key_code == SC_SPACE) begin
          sustain <= 1'b0;
          if (|pending) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (pending[v]) begin
                voice_active[v] <= 1'b0;
                vkey[v]         <= '0;
                vnote[v]        <= '0;
              end
            end
            pending        <= '0;
            note_off_pulse <= 1'b1;
            event_note     <= '0;
          end
        end else if (kidx != '0 && hit && sustain) begin
          pending[hit_v] <= 1'b1;
        end else
`endif
        if (kidx != '0 && hit) begin
          voice_active[hit_v] <= 1'b0;
          vkey[hit_v]         <= '0;
          vnote[hit_v]        <= '0;
          note_off_pulse      <= 1'b1;
          event_note          <= vnote[hit_v];
        end
      end
    end
  end

endmodule
